// File: rtl/instr_loader_pkg.sv
// Shared constants for the instruction loader: load-state encodings and the
// split of the 16-bit instruction word into opcode and operand fields.
package instr_loader_pkg;

  localparam logic [1:0] ST_WAIT_LO = 2'd0;
  localparam logic [1:0] ST_WAIT_HI = 2'd1;
  localparam logic [1:0] ST_LOADED  = 2'd2;

  localparam int WORD_W  = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int INSTR_W = 12;

endpackage

// File: rtl/instr_loader_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle press pulse on each accepted 0->1 change of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here uses non-blocking assignment so all flops
  // sample the same pre-edge values; blocking would chain them within a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      press  <= 1'b0;
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Flip and clear together, so the counter can never wrap.
        level <= ~level;
        cnt   <= '0;
        press <= ~level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Front end ahead of the CPU core: turns debounced button presses into either
// two-byte instruction loads (load_mode = 1) or single step strobes (load_mode = 0).
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data_in,
  input  logic                          btn_raw,
  input  logic                          load_mode,
  output logic [OPC_MSB-OPC_LSB:0]      opcode,
  output logic [INSTR_W-1:0]            instr,
  output logic                          inst_done,
  output logic                          btn_edge,
  output logic [1:0]                    load_state
);

  logic              press;
  logic [1:0]        state;
  logic [7:0]        lo_reg;
  logic [WORD_W-1:0] word;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_raw),
    .press  (press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_WAIT_LO;
      lo_reg    <= 8'h00;
      word      <= '0;
      inst_done <= 1'b0;
      btn_edge  <= 1'b0;
    end else begin
      inst_done <= 1'b0;
      btn_edge  <= 1'b0;
      if (!load_mode) begin
        btn_edge <= press;
        // Leaving load mode half way through abandons the partial word.
        if (state == ST_WAIT_HI) begin
          state  <= ST_WAIT_LO;
          lo_reg <= 8'h00;
        end
      end else if (press) begin
        case (state)
          ST_WAIT_HI: begin
            word      <= {data_in, lo_reg};
            state     <= ST_LOADED;
            inst_done <= 1'b1;
          end
          default: begin
            lo_reg <= data_in;
            state  <= ST_WAIT_HI;
          end
        endcase
      end
    end
  end

  assign opcode     = word[OPC_MSB:OPC_LSB];
  assign instr      = word[INSTR_W-1:0];
  assign load_state = state;

endmodule
